// File: rtl/onehot_sw_encoder_pkg.sv
// Shared types and encoding helpers for the switch-bank encoder and the code-to-LED path.
package onehot_pkg;

  localparam int SW_WIDTH   = 15;
  localparam int CODE_WIDTH = 4;

  typedef logic [SW_WIDTH-1:0]   sw_t;
  typedef logic [CODE_WIDTH-1:0] code_t;

  typedef struct packed {
    code_t code;
    logic  err;
  } report_t;

  // Zero -> 0, single bit i -> i+1, anything with two or more bits -> err with code 0.
  function automatic report_t encode_pattern(input sw_t pat);
    report_t     r;
    int unsigned ones;
    r    = '0;
    ones = 0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      if (pat[i]) begin
        ones   = ones + 1;
        r.code = code_t'(i + 1);
      end
    end
    if (ones > 1) begin
      r.code = '0;
      r.err  = 1'b1;
    end
    return r;
  endfunction

  function automatic sw_t code_to_led(input code_t c);
    sw_t led;
    led = '0;
    if (c != '0) begin
      led = sw_t'(1) << (c - code_t'(1));
    end
    return led;
  endfunction

endpackage

// File: rtl/onehot_sw_encoder_if.sv
// Report handshake between the encoder (master) and its consumer (slave).
interface onehot_sw_encoder_if;
  import onehot_pkg::*;

  code_t bcdNum;
  logic  valid;
  logic  err;
  logic  ack;

  modport master (output bcdNum, output valid, output err, input  ack);
  modport slave  (input  bcdNum, input  valid, input  err, output ack);

endinterface

// File: rtl/onehot_sw_encoder_sw_debounce.sv
// Two-flop synchronizer plus stability-window debouncer; pulses accept_o once per new stable pattern.
module sw_debounce
  import onehot_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] pattern_o,
  output logic             accept_o
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable;
  logic             accept;

  always_comb begin
    stable = (sync2_q == cand_q);
    accept = stable && (cnt_q == CNT_MAX) && (cand_q != last_q);
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (!stable) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A bounce back to the already-reported pattern saturates silently here.
    last_d = accept ? cand_q : last_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign pattern_o = cand_q;
  assign accept_o  = accept;

endmodule

// File: rtl/onehot_sw_encoder.sv
// Debounces a 15-bit switch bank and reports its one-hot code through a valid/ack handshake.
module onehot_sw_encoder
  import onehot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  sw_t                        sw,
  onehot_sw_encoder_if.master        rpt
);

  sw_t     pattern;
  logic    accept;
  report_t enc;
  report_t rpt_q, rpt_d;
  logic    valid_q, valid_d;

  sw_debounce #(
    .WIDTH          (SW_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .sw_i     (sw),
    .pattern_o(pattern),
    .accept_o (accept)
  );

  assign enc = encode_pattern(pattern);

  // Latest acceptance wins over a pending or simultaneous ack.
  always_comb begin
    valid_d = valid_q;
    rpt_d   = rpt_q;
    if (accept) begin
      valid_d = 1'b1;
      rpt_d   = enc;
    end else if (valid_q && rpt.ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      rpt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rpt_q   <= rpt_d;
    end
  end

  assign rpt.bcdNum = rpt_q.code;
  assign rpt.err    = rpt_q.err;
  assign rpt.valid  = valid_q;

endmodule

// File: tb/tb_onehot_sw_encoder.sv
// Directed and randomized bench for onehot_sw_encoder with a stability-window reference model.
module tb_onehot_sw_encoder;
  import onehot_pkg::*;

  localparam int N = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] sw    = '0;
  logic        ack   = 1'b0;

  int checks   = 0;
  int failures = 0;

  // smp[j] = sw sampled j edges ago; a pattern is accepted once N+1 consecutive
  // synchronized samples (two edges old) agree and differ from the last report.
  logic [14:0] smp [0:N+2];
  logic [14:0] m_last;
  logic        m_valid;
  logic [3:0]  m_code;
  logic        m_err;

  int          dut_reports;
  logic [3:0]  seen_code;

  onehot_sw_encoder_if rif ();
  assign rif.ack = ack;

  onehot_sw_encoder #(.DEBOUNCE_CYCLES(N)) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw),
    .rpt  (rif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_encode(input logic [14:0] p, output logic [3:0] c, output logic e);
    int ones;
    ones = $countones(p);
    c = '0;
    e = (ones > 1);
    if (ones == 1) c = 4'($clog2(p) + 1);
  endfunction

  task automatic model_clear();
    for (int j = 0; j <= N + 2; j++) smp[j] = '0;
    m_last  = '0;
    m_valid = 1'b0;
    m_code  = '0;
    m_err   = 1'b0;
  endtask

  task automatic tick();
    logic       same;
    logic [3:0] c;
    logic       e;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      for (int j = N + 2; j > 0; j--) smp[j] = smp[j-1];
      smp[0] = sw;
      same = 1'b1;
      for (int j = 3; j <= N + 2; j++) if (smp[j] != smp[2]) same = 1'b0;
      if (same && (smp[2] != m_last)) begin
        m_last = smp[2];
        ref_encode(smp[2], c, e);
        m_valid = 1'b1;
        m_code  = c;
        m_err   = e;
      end else if (m_valid && ack) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("model_valid", rif.valid, m_valid);
    chk("model_bcdNum", rif.bcdNum, m_code);
    chk("model_err", rif.err, m_err);
  endtask

  task automatic tick_count();
    tick();
    if (rif.valid === 1'b1) begin
      dut_reports++;
      seen_code = rif.bcdNum;
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b1;
    model_clear();
    #1;
    chk({tag, "_valid"}, rif.valid, 0);
    chk({tag, "_bcdNum"}, rif.bcdNum, 0);
    chk({tag, "_err"}, rif.err, 0);
  endtask

  initial begin
    int          sel;
    int          len;
    logic [14:0] p;
    model_clear();
    p = '0;

    // Reset state
    repeat (2) tick();
    chk("reset_valid", rif.valid, 0);
    chk("reset_bcdNum", rif.bcdNum, 0);
    chk("reset_err", rif.err, 0);
    #2 reset = 1'b0;

    // Clean one-hot change, report latency and ack
    sw = 15'h0004;
    repeat (6) tick();
    chk("lat_edge6_valid", rif.valid, 0);
    tick();
    chk("lat_edge7_valid", rif.valid, 1);
    chk("lat_edge7_bcdNum", rif.bcdNum, 3);
    chk("lat_edge7_err", rif.err, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_clear_valid", rif.valid, 0);
    chk("ack_keep_bcdNum", rif.bcdNum, 3);

    // Bouncing top bit, acked immediately so each report shows for one cycle
    ack = 1'b1;
    dut_reports = 0;
    seen_code = '0;
    for (int b = 0; b < 2; b++) begin
      sw = 15'h4000;
      repeat (3) tick_count();
      sw = 15'h0000;
      repeat (3) tick_count();
    end
    sw = 15'h4000;
    repeat (12) tick_count();
    ack = 1'b0;
    chk("bounce_reports", dut_reports, 1);
    chk("bounce_bcdNum", seen_code, 15);

    // Multi-bit error, then return to zero
    sw = 15'h0011;
    repeat (8) tick();
    chk("multi_valid", rif.valid, 1);
    chk("multi_bcdNum", rif.bcdNum, 0);
    chk("multi_err", rif.err, 1);
    sw = 15'h0000;
    repeat (8) tick();
    chk("zero_valid", rif.valid, 1);
    chk("zero_bcdNum", rif.bcdNum, 0);
    chk("zero_err", rif.err, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Overwrite of an unacked report, ack coinciding with acceptance
    sw = 15'h0001;
    repeat (8) tick();
    chk("ovw_first_bcdNum", rif.bcdNum, 1);
    sw = 15'h0100;
    repeat (6) tick();
    chk("ovw_pending_valid", rif.valid, 1);
    chk("ovw_pending_bcdNum", rif.bcdNum, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ovw_accept_valid", rif.valid, 1);
    chk("ovw_accept_bcdNum", rif.bcdNum, 9);
    tick();
    chk("ovw_hold_valid", rif.valid, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ovw_acked_valid", rif.valid, 0);

    // Async reset mid-count, then report of the held pattern after release
    sw = 15'h0008;
    repeat (4) tick();
    async_reset_check("rst_midcount");
    repeat (2) tick();
    #2 reset = 1'b0;
    repeat (7) tick();
    chk("rst_release_valid", rif.valid, 1);
    chk("rst_release_bcdNum", rif.bcdNum, 4);

    // Async reset while a report is pending, release with a new pattern
    async_reset_check("rst_pending");
    sw = 15'h0002;
    repeat (2) tick();
    #2 reset = 1'b0;
    repeat (6) tick();
    chk("rst2_edge6_valid", rif.valid, 0);
    tick();
    chk("rst2_edge7_valid", rif.valid, 1);
    chk("rst2_edge7_bcdNum", rif.bcdNum, 2);
    chk("rst2_edge7_err", rif.err, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (8) tick();
    chk("rst2_single_report", rif.valid, 0);

    // Randomized patterns, hold lengths and acks against the model
    for (int it = 0; it < 120; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 1)      p = '0;
      else if (sel <= 6) p = 15'(1) << $urandom_range(0, 14);
      else if (sel <= 8) p = 15'($urandom);
      sw  = p;
      len = int'($urandom_range(1, 10));
      repeat (len) begin
        ack = ($urandom_range(0, 2) == 0);
        tick();
      end
      if (it == 60) begin
        async_reset_check("rand_reset");
        tick();
        #2 reset = 1'b0;
      end
    end
    ack = 1'b0;

    // Fast toggling never settles, so nothing new may appear
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int t = 0; t < 20; t++) begin
      sw = (t % 2 == 0) ? 15'h7FFF : 15'h0040;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
